// File: rtl/rtc_bus_sequencer.sv
// RTC register burst sequencer: follows the strobe generator's frames, drives and
// turns around the multiplexed AD bus, and packs read-back bytes into rd_time.
module rtc_bus_sequencer #(
  parameter int         N_REGS    = 6,
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter int         TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_rd,
  input  logic                start_wr,
  input  logic [8*N_REGS-1:0] wr_time,
  input  logic                cs_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic                ad_n,
  input  logic [7:0]          ad_in,
  output logic                rw_mode,
  output logic [7:0]          ad_out,
  output logic                ad_oe,
  output logic [8*N_REGS-1:0] rd_time,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int         IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ADDR_W, S_ADDR, S_DATA_W, S_DATA, S_NEXT
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rw_mode_q, rw_mode_d;
  logic [7:0]           ad_out_q, ad_out_d;
  logic                 ad_oe_q, ad_oe_d;
  logic [8*N_REGS-1:0]  rd_time_q, rd_time_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [8*N_REGS-1:0]  wdata_q, wdata_d;

  // Strobes: two synchroniser flops plus a third for edge detection.
  logic [2:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic [1:0] adn_sync_q;
  logic [7:0] adin_s1_q, adin_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q  <= 3'b111;
      rd_sync_q  <= 3'b111;
      wr_sync_q  <= 3'b111;
      adn_sync_q <= 2'b11;
      adin_s1_q  <= '0;
      adin_s2_q  <= '0;
    end else begin
      cs_sync_q  <= {cs_sync_q[1:0], cs_n};
      rd_sync_q  <= {rd_sync_q[1:0], rd_n};
      wr_sync_q  <= {wr_sync_q[1:0], wr_n};
      adn_sync_q <= {adn_sync_q[0], ad_n};
      adin_s1_q  <= ad_in;
      adin_s2_q  <= adin_s1_q;
    end
  end

  logic cs_hi, cs_fall, cs_rise, rd_rise, wr_rise, strobe_rise, adn_hi;
  assign cs_hi   = cs_sync_q[1];
  assign cs_fall = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise = ~cs_sync_q[2] & cs_sync_q[1];
  assign rd_rise = ~rd_sync_q[2] & rd_sync_q[1];
  assign wr_rise = ~wr_sync_q[2] & wr_sync_q[1];
  assign adn_hi  = adn_sync_q[1];
  // Only the strobe matching the burst mode counts; the other one is ignored.
  assign strobe_rise = rw_mode_q ? rd_rise : wr_rise;

  // NOTE: every _d gets a default first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    idx_d     = idx_q;
    rw_mode_d = rw_mode_q;
    ad_out_d  = ad_out_q;
    ad_oe_d   = ad_oe_q;
    rd_time_d = rd_time_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wdata_d   = wdata_q;

    unique case (state_q)
      S_IDLE: if (start_rd || start_wr) begin
        state_d   = S_ARM;
        rw_mode_d = start_rd;
        err_d     = 1'b0;
        idx_d     = '0;
        wdata_d   = wr_time;
      end
      S_ARM: if (cs_hi) begin
        state_d  = S_ADDR_W;
        ad_out_d = ADDR_BASE + 8'(idx_q);
        ad_oe_d  = 1'b1;
      end
      S_ADDR_W: if (cs_fall && !adn_hi) state_d = S_ADDR;
      S_ADDR: if (cs_rise) begin
        state_d = S_DATA_W;
        // Read bursts release the bus here, well before the generator drops rd_n.
        if (rw_mode_q) ad_oe_d  = 1'b0;
        else           ad_out_d = wdata_q[{idx_q, 3'b000} +: 8];
      end
      S_DATA_W: if (cs_fall && adn_hi) state_d = S_DATA;
      S_DATA: begin
        if (rw_mode_q && strobe_rise) rd_time_d[{idx_q, 3'b000} +: 8] = adin_s2_q;
        if (cs_rise) begin
          state_d = S_NEXT;
          ad_oe_d = 1'b0;
        end
      end
      S_NEXT: if (idx_q == IDX_W'(N_REGS - 1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_ARM;
        idx_d   = idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_ARM, S_ADDR_W, S_ADDR, S_DATA_W, S_DATA} && state_d == state_q) begin
      if (wait_q == TMO) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        ad_oe_d = 1'b0;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      idx_q     <= '0;
      rw_mode_q <= 1'b0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      rd_time_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      rw_mode_q <= rw_mode_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      rd_time_q <= rd_time_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // NOTE: the write payload is only read after an accept loads it, so it carries no reset.
  always_ff @(posedge clk) wdata_q <= wdata_d;

  assign rw_mode = rw_mode_q;
  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;
  assign rd_time = rd_time_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule
